// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store controller.
// Holds the FSM state enum, the funct3 codes, the byte-enable masks and the size decode helpers.
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  localparam logic [31:0] BAD_VAL = 32'hBADB_AD00;

  // A return value of zero marks a funct3 code that is illegal for this direction.
  function automatic logic [3:0] f3_to_be(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B:    f3_to_be = BE_B;
      F3_H:    f3_to_be = BE_H;
      F3_W:    f3_to_be = BE_W;
      F3_BU:   f3_to_be = we ? 4'b0000 : BE_B;
      F3_HU:   f3_to_be = we ? 4'b0000 : BE_H;
      default: f3_to_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] be_nbytes(input logic [3:0] be);
    case (be)
      BE_B:    be_nbytes = 3'd1;
      BE_H:    be_nbytes = 3'd2;
      BE_W:    be_nbytes = 3'd4;
      default: be_nbytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request, response and memory-side signals of the load/store controller.
// The slave modport is the controller's view; master is the surrounding pipeline and memory.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata_raw;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [3:0]  mem_byte_en;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata_raw,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_wdata, mem_read_req, mem_write_req, mem_byte_en
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata_raw,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_wdata, mem_read_req, mem_write_req, mem_byte_en
  );
endinterface

// File: rtl/lsu_mem_ctrl_load_ext.sv
// Sign/zero extension of raw memory read data according to the load funct3.
// Bytes above the access size are ignored.
module lsu_load_ext
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_W:    o_data = i_raw;
      F3_BU:   o_data = {24'd0, i_raw[7:0]};
      F3_HU:   o_data = {16'd0, i_raw[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller in front of a byte-addressed data memory.
// Build option LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of going byte-wise.
//
// state  | meaning
// IDLE   | ready for a request, memory strobes low
// ACCESS | one-cycle memory strobe (suppressed on fault)
// RESP   | result held on the response port until consumed
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_ctrl_if.slave bus
);

  lsu_state_e  r_state;
  logic        r_we;
  logic        r_fault;
  logic [2:0]  r_funct3;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_fault;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_mem_rd;
  logic        r_mem_wr;

  logic [3:0]  w_be;
  logic [32:0] w_end;
  logic        w_misalign;
  logic        w_fault;
  logic [31:0] w_ext;

  assign w_be  = f3_to_be(bus.req_we, bus.req_funct3);
  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign w_end = {1'b0, bus.req_addr} + {30'd0, be_nbytes(w_be)};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((w_be == BE_H) && bus.req_addr[0]) ||
                      ((w_be == BE_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = (w_be == 4'b0000) || (w_end > 33'(MEM_SIZE)) || w_misalign;

  lsu_load_ext u_load_ext (
    .i_funct3 (r_funct3),
    .i_raw    (bus.mem_rdata_raw),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_fault      <= 1'b0;
      r_funct3     <= 3'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_we        <= bus.req_we;
            r_funct3    <= bus.req_funct3;
            r_fault     <= w_fault;
            r_mem_addr  <= bus.req_addr;
            r_mem_wdata <= bus.req_wdata;
            r_mem_be    <= w_fault ? 4'b0000 : w_be;
            r_mem_rd    <= !bus.req_we && !w_fault;
            r_mem_wr    <= bus.req_we && !w_fault;
            r_req_ready <= 1'b0;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_mem_rd     <= 1'b0;
          r_mem_wr     <= 1'b0;
          r_mem_be     <= 4'b0000;
          r_resp_valid <= 1'b1;
          r_resp_fault <= r_fault;
          r_resp_rdata <= r_fault ? BAD_VAL : (r_we ? 32'd0 : w_ext);
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_fault    = r_resp_fault;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_byte_en   = r_mem_be;
  assign bus.mem_read_req  = r_mem_rd;
  assign bus.mem_write_req = r_mem_wr;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller that sits directly upstream of the byte-addressed data memory model.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Drives the memory's address, write data, byte-enable and read/write strobes for exactly one cycle.
- Captures, sign- or zero-extends the returned data and holds the result on a valid/ready response port until the writeback stage consumes it.

Parameters:
- MEM_SIZE, 4096: bytes of backing memory; accesses with addr+nbytes > MEM_SIZE fault.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-justified
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_rdata  out  32  extended load data; 0 for stores; BAD_VAL on fault
- resp_fault  out  1  access rejected
- mem_addr  out  32  byte address to memory
- mem_wdata  out  32  low-justified store data
- mem_rdata_raw  in  32  combinational read data; byte i = mem[mem_addr+i]
- mem_read_req  out  1  read strobe
- mem_write_req  out  1  write strobe; memory commits at posedge
- mem_byte_en  out  4  low-justified enables: 0001 byte, 0011 half, 1111 word

Behaviour:
- Reset values (immediate on rst):
  - state=IDLE
  - req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0
  - mem_addr=0, mem_wdata=0, mem_byte_en=0, mem_read_req=0, mem_write_req=0
- States IDLE -> ACCESS -> RESP -> IDLE:
  - IDLE: on req_valid&&req_ready at edge N, register we/funct3/addr/wdata and decode size and fault; go to ACCESS.
  - ACCESS (cycle N+1):
    - Strobes are combinational from state: mem_read_req=!we&&!fault; mem_write_req=we&&!fault; mem_addr/mem_wdata/mem_byte_en from the registered request.
    - At edge N+2, the store commits in memory, or mem_rdata_raw is extended into resp_rdata. Go to RESP.
    - Strobes are high for exactly this one cycle and are 0 in every other state.
  - RESP:
    - resp_valid=1; resp_rdata/resp_fault are held stable while resp_valid&&!resp_ready.
    - On resp_ready, go to IDLE. No new request is accepted in that same cycle (req_ready is low in RESP).
- Latency: request handshake to resp_valid = 2 cycles; minimum issue interval = 3 cycles.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code: fault.
- Extension:
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - Bits of mem_rdata_raw outside the byte enables are ignored.
- Bounds: compute {1'b0,addr}+nbytes in 33 bits so the sum cannot wrap. Sum > MEM_SIZE -> fault; e.g. addr 0xFFFFFFFF with LB faults.
- Fault:
  - No strobe is raised in ACCESS.
  - resp_fault=1, resp_rdata=BAD_VAL.
  - Latency is unchanged.
- Stores: resp_rdata=0, resp_fault=0 when the store succeeds.
- Reset mid-operation: any state returns to IDLE. A store whose ACCESS cycle is cut by rst before the edge is not committed. A pending response is discarded.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]!=0 or a word with addr[1:0]!=0 sets resp_fault=1; no memory strobe is raised.
- Undefined: misaligned accesses are performed byte-wise at the given address with no fault; only the bounds and funct3 checks apply.

Decomposition:
- typepkg additions:
  - lsu_state_e (IDLE, ACCESS, RESP)
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - byte-enable constants (BE_B=4'b0001, BE_H=4'b0011, BE_W=4'b1111)
  - reuse existing BAD_VAL
- One sub-module: lsu_load_ext. Combinational; funct3 + raw data -> extended 32-bit result.

Test Plan:
1. SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> mem_byte_en=1111 for one cycle on each; resp_rdata=0xDEADBEEF two cycles after the handshake; fault=0.
2. SB 0x200 data 0x80; LB 0x200 -> 0xFFFFFF80; LBU 0x200 -> 0x00000080; SH 0x204 0x8001, LHU -> 0x00008001.
3. LW addr 0xFFE (MEM_SIZE 4096) and LB 0xFFFFFFFF -> resp_fault=1, resp_rdata=BAD_VAL, no mem_read_req pulse.
4. LH addr 0x101 -> without macro: data from bytes 0x101..0x102, fault=0; with LSU_MISALIGN_TRAP_EN: fault=1, no strobe.
5. Hold resp_ready=0 for 5 cycles while pulsing req_valid -> req_ready=0 and resp_rdata stable throughout; the next request is accepted only after resp_ready.
6. Assert rst during the ACCESS cycle of SW 0x300 0x12345678 (prior contents 0) -> outputs reset immediately; a subsequent LW 0x300 returns 0.
